servo_frame_seq: RTL and testbench

Sequencer for the servo PWM comparator datapath. Generates the 1 us tick and the 20 ms frame counter (cntr_val), accepts new joystick positions from the SPI receiver over a valid/ready handshake, and applies them only at frame boundaries. Updates are slew-rate limited, and the servo returns to centre (failsafe) when SPI data stops arriving. Drives cntr_val and y_val into the PWM comparator.

---
 rtl/servo_frame_seq_if.sv | 15 +
 rtl/servo_frame_seq.sv | 145 ++++++++++++++
 tb/tb_servo_frame_seq.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_frame_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : servo_frame_seq_if
// Description : Position handshake from the SPI receiver into the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_frame_seq_if;
    logic       pos_valid;
    logic [9:0] pos_data;
    logic       pos_ready;

    modport master (output pos_valid, output pos_data, input pos_ready);
    modport slave  (input pos_valid, input pos_data, output pos_ready);
endinterface
`default_nettype wire

// File: rtl/servo_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : servo_frame_seq
// Description : 1 us tick, 20 ms frame counter and slew-limited, failsafe-
//               protected pulse-width sequencer for the servo PWM comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module servo_frame_seq #(
    parameter int TICK_DIV       = 100,
    parameter int PERIOD_TICKS   = 20000,
    parameter int PULSE_MIN      = 1000,
    parameter int PULSE_MAX      = 2000,
    parameter int PULSE_CENTER   = 1500,
    parameter int SLEW_STEP      = 50,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    servo_frame_seq_if.slave   pos_if,
    output logic [14:0]        cntr_val,
    output logic [10:0]        y_val,
    output logic               frame_start,
    output logic               failsafe
);

    localparam int c_PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TO_W = $clog2(TIMEOUT_FRAMES + 1);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_RUN      = 2'd1;
    localparam logic [1:0] c_FAILSAFE = 2'd2;

    logic [1:0]        r_state;
    logic [c_PS_W-1:0] r_presc;
    logic [10:0]       r_target;
    logic [10:0]       r_pending;
    logic              r_pending_flag;
    logic [c_TO_W-1:0] r_to_cnt;

    logic              w_tick;
    logic              w_wrap;
    logic              w_accept;
    logic [10:0]       w_pos_pulse;
    logic [c_TO_W-1:0] w_to_inc;
    logic              w_timeout;
    logic [10:0]       w_next_target;
    logic [10:0]       w_diff;
    logic [10:0]       w_y_next;

    assign pos_if.pos_ready = (r_state != c_IDLE);

    assign w_tick   = (r_presc == c_PS_W'(TICK_DIV - 1));
    assign w_wrap   = (r_state != c_IDLE) && w_tick &&
                      (cntr_val == 15'(PERIOD_TICKS - 1));
    assign w_accept = pos_if.pos_valid && pos_if.pos_ready;

    // Positions above full-right saturate to PULSE_MAX.
    assign w_pos_pulse = 11'(PULSE_MIN) +
                         ((pos_if.pos_data > 10'd1000) ? 11'd1000 : {1'b0, pos_if.pos_data});

    assign w_to_inc  = (r_to_cnt == c_TO_W'(TIMEOUT_FRAMES)) ? r_to_cnt
                                                             : r_to_cnt + c_TO_W'(1);
    // A same-cycle accept clears the counter, so it cannot trip the timeout.
    assign w_timeout = (r_state == c_RUN) && !r_pending_flag && !w_accept &&
                       (w_to_inc == c_TO_W'(TIMEOUT_FRAMES));

    always_comb begin
        w_next_target = r_target;
        if (r_pending_flag) begin
            w_next_target = r_pending;
        end else if (w_timeout) begin
            w_next_target = 11'(PULSE_CENTER);
        end

        // Compare before subtracting so the unsigned difference never wraps.
        w_diff   = 11'd0;
        w_y_next = y_val;
        if (w_next_target >= y_val) begin
            w_diff   = w_next_target - y_val;
            w_y_next = (w_diff <= 11'(SLEW_STEP)) ? w_next_target : y_val + 11'(SLEW_STEP);
        end else begin
            w_diff   = y_val - w_next_target;
            w_y_next = (w_diff <= 11'(SLEW_STEP)) ? w_next_target : y_val - 11'(SLEW_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            r_state        <= c_IDLE;
            r_presc        <= '0;
            cntr_val       <= '0;
            y_val          <= '0;
            r_target       <= '0;
            r_pending_flag <= 1'b0;
            r_to_cnt       <= '0;
            frame_start    <= 1'b0;
            failsafe       <= 1'b0;
            if (rst) begin
                r_pending <= '0;
            end
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_state        <= c_RUN;
                    y_val          <= 11'(PULSE_CENTER);
                    r_target       <= 11'(PULSE_CENTER);
                    r_to_cnt       <= '0;
                    r_pending_flag <= 1'b0;
                end
                c_RUN, c_FAILSAFE: begin
                    r_presc     <= w_tick ? '0 : r_presc + c_PS_W'(1);
                    frame_start <= w_wrap;
                    if (w_tick) begin
                        cntr_val <= w_wrap ? 15'd0 : cntr_val + 15'd1;
                    end
                    if (w_wrap) begin
                        r_target <= w_next_target;
                        y_val    <= w_y_next;
                        r_to_cnt <= w_to_inc;
                        if (r_pending_flag) begin
                            r_pending_flag <= 1'b0;
                            r_state        <= c_RUN;
                            failsafe       <= 1'b0;
                        end else if (w_timeout) begin
                            r_state  <= c_FAILSAFE;
                            failsafe <= 1'b1;
                        end
                    end
                    // Placed last so a same-cycle accept overrides the boundary.
                    if (w_accept) begin
                        r_pending      <= w_pos_pulse;
                        r_pending_flag <= 1'b1;
                        r_to_cnt       <= '0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_servo_frame_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_servo_frame_seq
// Description : Self-checking bench for servo_frame_seq (short frames).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_frame_seq;

    localparam int c_PERIOD = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [14:0] cntr_val, cntr2;
    logic [10:0] y_val, y2;
    logic        frame_start, fs2, failsafe, fsafe2;

    servo_frame_seq_if pif ();
    servo_frame_seq_if pif2 ();

    always #5 clk = ~clk;

    servo_frame_seq #(.TICK_DIV(1), .PERIOD_TICKS(c_PERIOD)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pos_if(pif),
        .cntr_val(cntr_val), .y_val(y_val), .frame_start(frame_start), .failsafe(failsafe)
    );

    // Second instance exercises the prescaler with a tiny frame.
    servo_frame_seq #(.TICK_DIV(3), .PERIOD_TICKS(5)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .pos_if(pif2),
        .cntr_val(cntr2), .y_val(y2), .frame_start(fs2), .failsafe(fsafe2)
    );

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int model_y;

    typedef struct {
        logic [9:0] pos;
        int         pulse;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!frame_start && n < c_PERIOD + 5);
        if (!frame_start) begin
            total++;
            bad++;
            $display("FAIL frame_wait: no frame_start after %0d cycles", n);
        end
    endtask

    task automatic wait_cntr(input int v);
        int n = 0;
        while (cntr_val != 15'(v) && n < c_PERIOD + 5) begin
            step();
            n++;
        end
        if (cntr_val != 15'(v)) begin
            total++;
            bad++;
            $display("FAIL cntr_wait: cntr_val=%0d never reached %0d", cntr_val, v);
        end
    endtask

    task automatic send(input logic [9:0] d);
        pif.pos_valid = 1'b1;
        pif.pos_data  = d;
        step();
        pif.pos_valid = 1'b0;
    endtask

    function automatic int slew(input int y, input int t);
        if (t > y) return (t - y <= 50) ? t : y + 50;
        return (y - t <= 50) ? t : y - 50;
    endfunction

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, viol, first_fs, cerr, early, m, e;
        tbl[0] = '{10'd1000, 2000};
        tbl[1] = '{10'd1023, 2000};
        tbl[2] = '{10'd250,  1250};
        tbl[3] = '{10'd777,  1777};
        tbl[4] = '{10'd0,    1000};
        tbl[5] = '{10'd1000, 2000};

        rst = 1'b1;
        enable = 1'b0;
        pif.pos_valid = 1'b0;
        pif.pos_data  = '0;
        pif2.pos_valid = 1'b0;
        pif2.pos_data  = '0;
        repeat (3) step();
        check("rst_cntr", cntr_val, 0);
        check("rst_y", y_val, 0);
        check("rst_ready", pif.pos_ready, 0);
        check("rst_failsafe", failsafe, 0);
        check("rst_frame_start", frame_start, 0);

        rst = 1'b0;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (frame_start || cntr_val != 0 || y_val != 0 || pif.pos_ready) viol++;
        end
        check("idle_quiet", viol, 0);

        // Frame timing from the first RUN cycle.
        enable = 1'b1;
        step();
        check("run_y_center", y_val, 1500);
        check("run_cntr0", cntr_val, 0);
        check("run_ready", pif.pos_ready, 1);
        check("run_failsafe", failsafe, 0);
        check("dut2_k0", cntr2, 0);
        first_fs = -1;
        cerr = 0;
        for (int k = 1; k <= c_PERIOD; k++) begin
            step();
            if (frame_start && first_fs < 0) first_fs = k;
            if (cntr_val != 15'(k % c_PERIOD)) cerr++;
            if (k == 2)  check("dut2_k2", cntr2, 0);
            if (k == 3)  check("dut2_k3", cntr2, 1);
            if (k == 14) check("dut2_k14", cntr2, 4);
            if (k == 15) begin
                check("dut2_k15_cntr", cntr2, 0);
                check("dut2_k15_fs", fs2, 1);
            end
        end
        check("cntr_seq", cerr, 0);
        check("first_frame_start", first_fs, c_PERIOD);
        step();
        check("frame_start_one_cycle", frame_start, 0);
        wait_frame(n);
        check("frame_period", n + 1, c_PERIOD);
        check("frame_y_center", y_val, 1500);
        model_y = 1500;

        // Positions applied mid-frame; expected per-boundary steps go to the scoreboard.
        for (int i = 0; i < 6; i++) begin
            wait_cntr(c_PERIOD / 2);
            send(tbl[i].pos);
            check("midframe_hold", y_val, model_y);
            m = model_y;
            do begin
                m = slew(m, tbl[i].pulse);
                exp_q.push_back(m);
            end while (m != tbl[i].pulse);
            exp_q.push_back(tbl[i].pulse);
            while (exp_q.size() > 0) begin
                wait_frame(n);
                e = exp_q.pop_front();
                check($sformatf("slew_v%0d", i), y_val, e);
            end
            model_y = tbl[i].pulse;
        end

        // Data arriving in the wrap cycle waits for the following boundary.
        wait_cntr(c_PERIOD - 1);
        pif.pos_valid = 1'b1;
        pif.pos_data  = 10'd0;
        step();
        pif.pos_valid = 1'b0;
        check("collide_fs", frame_start, 1);
        check("collide_hold", y_val, 2000);
        wait_frame(n);
        check("collide_step", y_val, 1950);
        wait_cntr(c_PERIOD / 2);
        send(10'd1000);
        wait_frame(n);
        check("back_to_max", y_val, 2000);

        // No more data: failsafe at the 25th boundary after the last accept.
        early = 0;
        for (int b = 2; b <= 24; b++) begin
            wait_frame(n);
            if (failsafe) early++;
        end
        check("no_early_failsafe", early, 0);
        wait_frame(n);
        check("timeout_failsafe", failsafe, 1);
        check("timeout_first_step", y_val, 1950);
        for (int b = 26; b <= 34; b++) wait_frame(n);
        check("failsafe_center", y_val, 1500);
        check("failsafe_still", failsafe, 1);
        check("failsafe_ready", pif.pos_ready, 1);
        wait_cntr(c_PERIOD / 2);
        send(10'd0);
        check("failsafe_until_boundary", failsafe, 1);
        wait_frame(n);
        check("recover_failsafe", failsafe, 0);
        check("recover_step", y_val, 1450);

        // Disable mid-frame, then restart.
        wait_cntr(70);
        enable = 1'b0;
        step();
        check("dis_cntr", cntr_val, 0);
        check("dis_y", y_val, 0);
        check("dis_ready", pif.pos_ready, 0);
        check("dis_failsafe", failsafe, 0);
        repeat (5) step();
        check("dis_cntr_held", cntr_val, 0);
        enable = 1'b1;
        step();
        check("reen_y", y_val, 1500);
        check("reen_cntr", cntr_val, 0);
        check("reen_ready", pif.pos_ready, 1);
        step();
        check("reen_cntr1", cntr_val, 1);
        wait_frame(n);
        check("reen_frame_period", n + 1, c_PERIOD);
        check("reen_frame_y", y_val, 1500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
